// File: rtl/wb_arbiter2_if.sv
// Bus bundle between two Wishbone-like masters, the shared slave and the arbiter.
// The arbiter connects through the "slave" modport. Bench/master logic connects through "master".
interface wb_arbiter2_if #(
    parameter int WIDTH = 32,
    parameter int ABITS = 10
);
    logic             m0_cyc_i, m0_stb_i, m0_we_i, m0_bst_i;
    logic [ABITS-1:0] m0_adr_i;
    logic [WIDTH-1:0] m0_dat_i;
    logic             m0_ack_o, m0_wat_o, m0_err_o;
    logic [WIDTH-1:0] m0_dat_o;

    logic             m1_cyc_i, m1_stb_i, m1_we_i, m1_bst_i;
    logic [ABITS-1:0] m1_adr_i;
    logic [WIDTH-1:0] m1_dat_i;
    logic             m1_ack_o, m1_wat_o, m1_err_o;
    logic [WIDTH-1:0] m1_dat_o;

    logic             s_cyc_o, s_stb_o, s_we_o, s_bst_o;
    logic [ABITS-1:0] s_adr_o;
    logic [WIDTH-1:0] s_dat_o;
    logic             s_ack_i, s_wat_i, s_err_i;
    logic [WIDTH-1:0] s_dat_i;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_bst_i, m0_adr_i, m0_dat_i,
        output m0_ack_o, m0_wat_o, m0_err_o, m0_dat_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_bst_i, m1_adr_i, m1_dat_i,
        output m1_ack_o, m1_wat_o, m1_err_o, m1_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_bst_o, s_adr_o, s_dat_o,
        input  s_ack_i, s_wat_i, s_err_i, s_dat_i
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_bst_i, m0_adr_i, m0_dat_i,
        input  m0_ack_o, m0_wat_o, m0_err_o, m0_dat_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_bst_i, m1_adr_i, m1_dat_i,
        input  m1_ack_o, m1_wat_o, m1_err_o, m1_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_bst_o, s_adr_o, s_dat_o,
        output s_ack_i, s_wat_i, s_err_i, s_dat_i
    );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master round-robin arbiter in front of one slave. The grant is registered and held
// for the master's whole cyc. Handover to a waiting master happens with no idle cycle.
module wb_arbiter2 (
    input  logic              clk_i,
    input  logic              rst_ni,
    wb_arbiter2_if.slave      bus,
    output logic [1:0]        gnt_o
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } gnt_e;

    gnt_e gnt_q, gnt_d;
    logic last_q, last_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q  <= IDLE;
            last_q <= 1'b1;
        end else begin
            gnt_q  <= gnt_d;
            last_q <= last_d;
        end
    end

    always_comb begin
        gnt_d  = IDLE;
        last_d = last_q;
        case (gnt_q)
            IDLE: begin
                // On a tie, grant the master that was not served most recently.
                if (bus.m0_cyc_i && bus.m1_cyc_i) gnt_d = last_q ? G0 : G1;
                else if (bus.m0_cyc_i)            gnt_d = G0;
                else if (bus.m1_cyc_i)            gnt_d = G1;
            end
            G0: begin
                if (bus.m0_cyc_i)      gnt_d = G0;
                else if (bus.m1_cyc_i) gnt_d = G1;
            end
            G1: begin
                if (bus.m1_cyc_i)      gnt_d = G1;
                else if (bus.m0_cyc_i) gnt_d = G0;
            end
            default: gnt_d = IDLE;
        endcase
        if (gnt_d == G0 && gnt_q != G0) last_d = 1'b0;
        if (gnt_d == G1 && gnt_q != G1) last_d = 1'b1;
    end

    // The slave side is a pure mux of the granted master. IDLE drives all zeros.
    always_comb begin
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_bst_o = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        case (gnt_q)
            G0: begin
                bus.s_cyc_o = bus.m0_cyc_i;
                bus.s_stb_o = bus.m0_stb_i;
                bus.s_we_o  = bus.m0_we_i;
                bus.s_bst_o = bus.m0_bst_i;
                bus.s_adr_o = bus.m0_adr_i;
                bus.s_dat_o = bus.m0_dat_i;
            end
            G1: begin
                bus.s_cyc_o = bus.m1_cyc_i;
                bus.s_stb_o = bus.m1_stb_i;
                bus.s_we_o  = bus.m1_we_i;
                bus.s_bst_o = bus.m1_bst_i;
                bus.s_adr_o = bus.m1_adr_i;
                bus.s_dat_o = bus.m1_dat_i;
            end
            default: ;
        endcase
    end

    assign bus.m0_dat_o = bus.s_dat_i;
    assign bus.m1_dat_o = bus.s_dat_i;
    assign bus.m0_ack_o = bus.s_ack_i & gnt_q[0];
    assign bus.m1_ack_o = bus.s_ack_i & gnt_q[1];
    assign bus.m0_err_o = bus.s_err_i & gnt_q[0];
    assign bus.m1_err_o = bus.s_err_i & gnt_q[1];
    // A requesting master that does not hold the grant is told to wait.
    assign bus.m0_wat_o = gnt_q[0] ? bus.s_wat_i : bus.m0_cyc_i;
    assign bus.m1_wat_o = gnt_q[1] ? bus.s_wat_i : bus.m1_cyc_i;

    assign gnt_o = gnt_q;
endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: reset, solo grant, tie-break, burst hold, round-robin,
// error routing and asynchronous reset mid-burst.
module tb_wb_arbiter2;
    logic       clk = 1'b0;
    logic       rst_ni;
    logic [1:0] gnt;
    int         total = 0;
    int         fails = 0;
    int         c0, c1;
    logic [1:0] exp_g;

    always #5 clk = ~clk;

    wb_arbiter2_if #(.WIDTH(32), .ABITS(10)) bus ();

    wb_arbiter2 dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus),
        .gnt_o (gnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0; bus.m0_bst_i = 0;
        bus.m0_adr_i = '0; bus.m0_dat_i = '0;
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0; bus.m1_bst_i = 0;
        bus.m1_adr_i = '0; bus.m1_dat_i = '0;
        bus.s_ack_i = 0; bus.s_wat_i = 0; bus.s_err_i = 0; bus.s_dat_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, slave ack must not leak through while idle
        clear_inputs();
        rst_ni = 1'b0;
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 32'h0000_A5A5;
        #2;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_scyc", 32'(bus.s_cyc_o), 32'h0);
        chk("rst_m0ack", 32'(bus.m0_ack_o), 32'h0);
        chk("rst_m1ack", 32'(bus.m1_ack_o), 32'h0);
        chk("rst_m1wat", 32'(bus.m1_wat_o), 32'h0);
        chk("rst_sadr", 32'(bus.s_adr_o), 32'h0);
        chk("rst_m0dat", bus.m0_dat_o, 32'h0000_A5A5);
        #10 rst_ni = 1'b1;
        bus.s_ack_i = 1'b0;

        // m0 alone: no combinational grant, registered from the first edge
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 10'd5; bus.m0_dat_i = 32'hDEAD_0000;
        #1;
        chk("solo_pre_gnt", 32'(gnt), 32'h0);
        chk("solo_pre_scyc", 32'(bus.s_cyc_o), 32'h0);
        chk("solo_pre_m0wat", 32'(bus.m0_wat_o), 32'h1);
        tick();
        chk("solo_gnt", 32'(gnt), 32'h1);
        bus.s_ack_i = 1;
        for (int i = 0; i < 4; i++) begin
            bus.m0_adr_i = 10'(i + 5);
            #1;
            chk("solo_scyc", 32'(bus.s_cyc_o), 32'h1);
            chk("solo_sadr", 32'(bus.s_adr_o), 32'(i + 5));
            chk("solo_sdat", bus.s_dat_o, 32'hDEAD_0000);
            chk("solo_m0ack", 32'(bus.m0_ack_o), 32'h1);
            chk("solo_m1out", {29'h0, bus.m1_ack_o, bus.m1_wat_o, bus.m1_err_o}, 32'h0);
            tick();
            chk("solo_hold", 32'(gnt), 32'h1);
        end
        bus.s_ack_i = 0;
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
        #1;
        chk("release_scyc", 32'(bus.s_cyc_o), 32'h0);
        chk("release_gnt", 32'(gnt), 32'h1);
        tick();
        chk("release_idle", 32'(gnt), 32'h0);

        // Tie after reset goes to m0, then direct handover to m1
        clear_inputs();
        rst_ni = 0; #2; rst_ni = 1;
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 10'h100;
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 10'h200; bus.m1_we_i = 1;
        tick();
        chk("tie_gnt", 32'(gnt), 32'h1);
        chk("tie_sadr", 32'(bus.s_adr_o), 32'h100);
        bus.s_ack_i = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("tie_m0ack", 32'(bus.m0_ack_o), 32'h1);
            chk("tie_m1ack", 32'(bus.m1_ack_o), 32'h0);
            chk("tie_m1wat", 32'(bus.m1_wat_o), 32'h1);
            tick();
        end
        bus.s_ack_i = 0;
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
        #1;
        chk("hand_m1wat", 32'(bus.m1_wat_o), 32'h1);
        chk("hand_scyc", 32'(bus.s_cyc_o), 32'h0);
        tick();
        chk("hand_gnt", 32'(gnt), 32'h2);
        chk("hand_sadr", 32'(bus.s_adr_o), 32'h200);
        chk("hand_swe", 32'(bus.s_we_o), 32'h1);
        chk("hand_m1wat", 32'(bus.m1_wat_o), 32'h0);

        // 24-word burst by m0, m1 requests from word 5 and must wait
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0;
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_bst_i = 1; bus.m0_adr_i = '0;
        tick();
        chk("bst_gnt", 32'(gnt), 32'h1);
        for (int i = 0; i < 24; i++) begin
            bus.m0_adr_i = 10'(i);
            if (i == 5) begin
                bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
            end
            #1;
            chk("bst_sadr", 32'(bus.s_adr_o), 32'(i));
            chk("bst_sbst", 32'(bus.s_bst_o), 32'h1);
            chk("bst_hold", 32'(gnt), 32'h1);
            if (i >= 5) chk("bst_m1wat", 32'(bus.m1_wat_o), 32'h1);
            tick();
        end
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_bst_i = 0;
        tick();
        chk("bst_after", 32'(gnt), 32'h2);

        // Round-robin: both keep requesting, each grant lasts 2 cycles
        bus.m1_cyc_i = 0;
        tick();
        chk("rr_idle", 32'(gnt), 32'h0);
        bus.m0_cyc_i = 1; bus.m1_cyc_i = 1;
        tick();
        c0 = 0; c1 = 0;
        for (int g = 0; g < 20; g++) begin
            exp_g = (g % 2 == 1) ? 2'b10 : 2'b01;
            chk("rr_gnt", 32'(gnt), 32'(exp_g));
            if (gnt == 2'b01) c0++;
            else if (gnt == 2'b10) c1++;
            tick();
            chk("rr_hold", 32'(gnt), 32'(exp_g));
            if (exp_g == 2'b01) bus.m0_cyc_i = 0;
            else bus.m1_cyc_i = 0;
            tick();
            bus.m0_cyc_i = 1; bus.m1_cyc_i = 1;
        end
        chk("rr_cnt0", 32'(c0), 32'd10);
        chk("rr_cnt1", 32'(c1), 32'd10);
        bus.m0_cyc_i = 0; bus.m1_cyc_i = 0;
        tick();
        chk("rr_end", 32'(gnt), 32'h0);

        // Error pulse during an m1 read
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 0; bus.m1_adr_i = 10'h033;
        tick();
        chk("err_gnt", 32'(gnt), 32'h2);
        bus.s_err_i = 1;
        #1;
        chk("err_m1err", 32'(bus.m1_err_o), 32'h1);
        chk("err_m0err", 32'(bus.m0_err_o), 32'h0);
        tick();
        bus.s_err_i = 0;
        #1;
        chk("err_clear", 32'(bus.m1_err_o), 32'h0);
        chk("err_keep", 32'(gnt), 32'h2);
        tick();
        chk("err_keep2", 32'(gnt), 32'h2);
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
        tick();
        chk("err_idle", 32'(gnt), 32'h0);

        // Asynchronous reset mid-burst, then tie goes to m0 again
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_bst_i = 1;
        tick();
        chk("arst_pre", 32'(gnt), 32'h1);
        bus.s_ack_i = 1;
        #3 rst_ni = 0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'h0);
        chk("arst_scyc", 32'(bus.s_cyc_o), 32'h0);
        chk("arst_m0ack", 32'(bus.m0_ack_o), 32'h0);
        bus.s_ack_i = 0;
        // m0 won the last grant before reset; reset must restore the m0 preference
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
        #1 rst_ni = 1;
        tick();
        chk("arst_tie", 32'(gnt), 32'h1);
        chk("arst_sbst", 32'(bus.s_bst_o), 32'h1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
